// File: rtl/fetch_realign_unit.sv
// Fetch realignment: turns 32-bit word-aligned fetch responses into a stream
// of 16-bit-aligned instruction candidates (RVC halves or full 32-bit words),
// stitching 32-bit instructions that straddle a word boundary.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_EMPTY | no buffered word; waiting for a fetch response
// ST_LO    | buffered word, next candidate starts at its lower halfword
// ST_HI    | buffered word, next candidate starts at its upper halfword
//          | (a non-RVC upper half is stitched with the next fetch word)
module fetch_realign_unit #(
  parameter int unsigned XLEN = 64
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_flush,
  input  logic [XLEN-1:0] i_flush_pc,
  input  logic            i_fetch_valid,
  output logic            o_fetch_ready,
  input  logic [31:0]     i_fetch_data,
  input  logic [XLEN-1:0] i_fetch_addr,
  output logic            o_instr_valid,
  input  logic            i_instr_ready,
  output logic [31:0]     o_instr,
  output logic [XLEN-1:0] o_instr_pc
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_LO    = 2'd1,
    ST_HI    = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [31:0]     w_q, w_d;
  logic [XLEN-1:0] w_pc_q, w_pc_d;
  logic            skip_q, skip_d;

  logic            lo_cmp;
  logic            hi_cmp;
  logic [XLEN-1:0] pc_hi;

  // Only bit 1 of the redirect PC matters: word alignment is implied.
  logic unused_flush_pc;
  assign unused_flush_pc = ^{i_flush_pc[XLEN-1:2], i_flush_pc[0]};

  // A halfword whose two low bits are not 2'b11 is a complete RVC instruction.
  assign lo_cmp = (w_q[1:0] != 2'b11);
  assign hi_cmp = (w_q[17:16] != 2'b11);
  assign pc_hi  = w_pc_q + XLEN'(2);

  // State, buffered word and its PC; skip_q remembers a halfword-aligned redirect.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_EMPTY;
      w_q     <= '0;
      w_pc_q  <= '0;
      skip_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      w_pc_q  <= w_pc_d;
      skip_q  <= skip_d;
    end
  end

  // Next-state and candidate selection; outputs stay zero unless a candidate is valid.
  always_comb begin
    state_d       = state_q;
    w_d           = w_q;
    w_pc_d        = w_pc_q;
    skip_d        = skip_q;
    o_instr_valid = 1'b0;
    o_instr       = '0;
    o_instr_pc    = '0;
    o_fetch_ready = 1'b0;

    if (i_flush) begin
      // Redirect beats everything: buffered and half-stitched data is dropped.
      state_d = ST_EMPTY;
      skip_d  = i_flush_pc[1];
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          o_fetch_ready = 1'b1;
          if (i_fetch_valid) begin
            w_d     = i_fetch_data;
            w_pc_d  = i_fetch_addr;
            state_d = skip_q ? ST_HI : ST_LO;
            skip_d  = 1'b0;
          end
        end

        ST_LO: begin
          o_instr_valid = 1'b1;
          o_instr_pc    = w_pc_q;
          if (lo_cmp) begin
            // Upper half still pending, so the word cannot be replaced yet.
            o_instr = {16'h0000, w_q[15:0]};
            if (i_instr_ready) begin
              state_d = ST_HI;
            end
          end else begin
            o_instr       = w_q;
            o_fetch_ready = i_instr_ready;
            if (i_instr_ready) begin
              if (i_fetch_valid) begin
                w_d     = i_fetch_data;
                w_pc_d  = i_fetch_addr;
                state_d = ST_LO;
              end else begin
                state_d = ST_EMPTY;
              end
            end
          end
        end

        ST_HI: begin
          o_fetch_ready = i_instr_ready;
          if (hi_cmp) begin
            o_instr_valid = 1'b1;
            o_instr       = {16'h0000, w_q[31:16]};
            o_instr_pc    = pc_hi;
            if (i_instr_ready) begin
              if (i_fetch_valid) begin
                w_d     = i_fetch_data;
                w_pc_d  = i_fetch_addr;
                state_d = ST_LO;
              end else begin
                state_d = ST_EMPTY;
              end
            end
          end else begin
            // Straddle: the upper half of the 32-bit instruction comes straight
            // from the fetch port, so validity follows the fetch response.
            o_instr_valid = i_fetch_valid;
            if (i_fetch_valid) begin
              o_instr    = {i_fetch_data[15:0], w_q[31:16]};
              o_instr_pc = pc_hi;
              if (i_instr_ready) begin
                w_d     = i_fetch_data;
                w_pc_d  = i_fetch_addr;
                state_d = ST_HI;
              end
            end
          end
        end

        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_realign_unit.sv
module tb_fetch_realign_unit;

  logic        clk         = 1'b0;
  logic        rst_n       = 1'b0;
  logic        flush       = 1'b0;
  logic [63:0] flush_pc    = '0;
  logic        fetch_valid = 1'b0;
  logic        fetch_ready;
  logic [31:0] fetch_data  = '0;
  logic [63:0] fetch_addr  = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b1;
  logic [31:0] instr;
  logic [63:0] instr_pc;

  always #5 clk = ~clk;

  fetch_realign_unit #(.XLEN(64)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_flush       (flush),
    .i_flush_pc    (flush_pc),
    .i_fetch_valid (fetch_valid),
    .o_fetch_ready (fetch_ready),
    .i_fetch_data  (fetch_data),
    .i_fetch_addr  (fetch_addr),
    .o_instr_valid (instr_valid),
    .i_instr_ready (instr_ready),
    .o_instr       (instr),
    .o_instr_pc    (instr_pc)
  );

  typedef struct { logic [15:0] h; logic [63:0] pc; } half_t;
  typedef struct { logic [31:0] data; logic [63:0] addr; } word_t;
  typedef struct { logic [31:0] instr; logic [63:0] pc; int cyc; logic fready; } out_t;

  half_t hq[$];     // halfwords accepted but not yet delivered, in program order
  word_t tx_q[$];   // words the upstream driver still has to deliver
  out_t  log_q[$];  // every accepted candidate as seen on the DUT outputs

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit skip  = 1'b0;
  int vprob = 100;
  int rprob = 100;
  bit stall_mode = 1'b0;
  int stall_cnt  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit is_c(logic [15:0] h);
    return h[1:0] != 2'b11;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: the fetch stream is a queue of halfwords; the next candidate is
  // the head halfword if it is RVC, otherwise the head and the following halfword
  // (taken from the fetch port when it is not yet buffered).
  always @(negedge clk) begin
    logic        e_valid;
    logic        e_ready;
    logic [31:0] e_instr;
    logic [63:0] e_pc;
    bit          outf;
    bit          inf;
    e_valid = 1'b0;
    e_ready = 1'b0;
    e_instr = '0;
    e_pc    = '0;
    if (!rst_n) begin
      e_ready = 1'b1;
    end else if (!flush) begin
      if (hq.size() == 0) begin
        e_ready = 1'b1;
      end else begin
        // A new word fits only if the buffered one can be retired this cycle.
        e_ready = (hq.size() >= 2 && is_c(hq[0].h)) ? 1'b0 : instr_ready;
        if (is_c(hq[0].h)) begin
          e_valid = 1'b1; e_instr = {16'h0000, hq[0].h}; e_pc = hq[0].pc;
        end else if (hq.size() >= 2) begin
          e_valid = 1'b1; e_instr = {hq[1].h, hq[0].h}; e_pc = hq[0].pc;
        end else if (fetch_valid) begin
          e_valid = 1'b1; e_instr = {fetch_data[15:0], hq[0].h}; e_pc = hq[0].pc;
        end
      end
    end
    chk("valid", 64'(instr_valid), 64'(e_valid));
    chk("fetch_ready", 64'(fetch_ready), 64'(e_ready));
    chk("instr", 64'(instr), 64'(e_instr));
    chk("instr_pc", instr_pc, e_pc);

    if (!rst_n) begin
      hq.delete();
      skip = 1'b0;
    end else if (flush) begin
      hq.delete();
      skip = flush_pc[1];
    end else begin
      outf = instr_valid && instr_ready;
      inf  = fetch_valid && fetch_ready;
      if (inf) begin
        if (!skip) hq.push_back('{fetch_data[15:0], fetch_addr});
        hq.push_back('{fetch_data[31:16], fetch_addr + 64'd2});
        skip = 1'b0;
      end
      if (outf) begin
        log_q.push_back('{instr, instr_pc, cyc, fetch_ready});
        if (hq.size() > 0) begin
          if (is_c(hq[0].h)) begin
            void'(hq.pop_front());
          end else begin
            void'(hq.pop_front());
            if (hq.size() > 0) void'(hq.pop_front());
          end
        end
      end
    end
  end

  // Upstream/downstream driver: presents tx_q words (held stable until taken)
  // and drives the downstream ready either randomly or as a 5-cycle stall.
  initial begin
    bit acc;
    bit fired;
    bit vis;
    forever begin
      @(negedge clk);
      acc   = fetch_valid && fetch_ready && rst_n && !flush;
      fired = instr_valid && instr_ready;
      vis   = instr_valid;
      @(posedge clk);
      #1;
      if (acc) begin
        fetch_valid = 1'b0;
        if (tx_q.size() > 0) void'(tx_q.pop_front());
      end
      if (!fetch_valid && tx_q.size() > 0 && int'($urandom_range(0, 99)) < vprob) begin
        fetch_valid = 1'b1;
        fetch_data  = tx_q[0].data;
        fetch_addr  = tx_q[0].addr;
      end
      if (stall_mode) begin
        if (fired) stall_cnt = 0;
        else if (vis) stall_cnt++;
        instr_ready = (stall_cnt >= 5);
      end else begin
        instr_ready = (int'($urandom_range(0, 99)) < rprob);
      end
    end
  end

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_log(int n, int budget, string name);
    int k = 0;
    while (log_q.size() < n && k < budget) begin
      tick(1);
      k++;
    end
    n_cmp++;
    if (log_q.size() < n) begin
      n_bad++;
      $display("FAIL %s_timeout: got %0d outputs expected %0d", name, log_q.size(), n);
    end
  endtask

  task automatic chk_out(string name, int idx, logic [31:0] ei, logic [63:0] ep);
    if (idx >= log_q.size()) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: output %0d missing, expected %h @ %h", name, idx, ei, ep);
    end else begin
      chk({name, "_instr"}, 64'(log_q[idx].instr), 64'(ei));
      chk({name, "_pc"}, log_q[idx].pc, ep);
    end
  endtask

  task automatic push_t2();
    tx_q.push_back('{32'h0513_4581, 64'h8000_0000});
    tx_q.push_back('{32'h4581_0005, 64'h8000_0004});
  endtask

  function automatic logic [15:0] rand_half();
    logic [15:0] h;
    h = 16'($urandom());
    if ($urandom_range(0, 1) == 1) h[1:0] = 2'b11;
    else h[1:0] = 2'($urandom_range(0, 2));
    return h;
  endfunction

  initial begin
    logic [63:0] next_addr;

    // reset values
    tick(3);
    chk("rst_valid", 64'(instr_valid), 64'd0);
    chk("rst_fetch_ready", 64'(fetch_ready), 64'd1);
    chk("rst_instr", 64'(instr), 64'd0);
    chk("rst_pc", instr_pc, 64'd0);
    rst_n = 1'b1;
    tick(2);

    // T1: two RVC halves in one word
    log_q.delete();
    tx_q.push_back('{32'h4501_4581, 64'h8000_0000});
    wait_log(2, 20, "t1");
    chk_out("t1_o0", 0, 32'h0000_4581, 64'h8000_0000);
    chk_out("t1_o1", 1, 32'h0000_4501, 64'h8000_0002);
    if (log_q.size() >= 2) begin
      chk("t1_fready_first", 64'(log_q[0].fready), 64'd0);
      chk("t1_gap", 64'(log_q[1].cyc - log_q[0].cyc), 64'd1);
    end

    // T2: straddling 32-bit instruction, back-to-back
    tick(3);
    log_q.delete();
    push_t2();
    wait_log(3, 30, "t2");
    chk_out("t2_o0", 0, 32'h0000_4581, 64'h8000_0000);
    chk_out("t2_o1", 1, 32'h0005_0513, 64'h8000_0002);
    chk_out("t2_o2", 2, 32'h0000_4581, 64'h8000_0006);
    if (log_q.size() >= 3) begin
      chk("t2_gap01", 64'(log_q[1].cyc - log_q[0].cyc), 64'd1);
      chk("t2_gap12", 64'(log_q[2].cyc - log_q[1].cyc), 64'd1);
    end

    // T3: same stream with a 5-cycle stall at each output
    tick(3);
    log_q.delete();
    stall_cnt   = 0;
    stall_mode  = 1'b1;
    instr_ready = 1'b0;
    push_t2();
    wait_log(3, 100, "t3");
    chk_out("t3_o0", 0, 32'h0000_4581, 64'h8000_0000);
    chk_out("t3_o1", 1, 32'h0005_0513, 64'h8000_0002);
    chk_out("t3_o2", 2, 32'h0000_4581, 64'h8000_0006);
    if (log_q.size() >= 3) begin
      chk("t3_stall01", 64'(log_q[1].cyc - log_q[0].cyc >= 6), 64'd1);
      chk("t3_stall12", 64'(log_q[2].cyc - log_q[1].cyc >= 6), 64'd1);
    end
    stall_mode = 1'b0;
    tick(3);
    chk("t3_count", 64'(log_q.size()), 64'd3);

    // T4: redirect to a halfword-aligned PC skips the low half
    log_q.delete();
    flush    = 1'b1;
    flush_pc = 64'h8000_0102;
    tick(1);
    flush = 1'b0;
    tx_q.push_back('{32'h4505_0001, 64'h8000_0100});
    wait_log(1, 20, "t4");
    tick(6);
    chk_out("t4_o0", 0, 32'h0000_4505, 64'h8000_0102);
    chk("t4_count", 64'(log_q.size()), 64'd1);

    // T5: flush while a straddle waits for its second half
    tick(2);
    log_q.delete();
    tx_q.push_back('{32'h0513_4581, 64'h8000_0200});
    wait_log(1, 20, "t5a");
    tick(3);
    chk("t5_straddle_wait_valid", 64'(instr_valid), 64'd0);
    chk_out("t5_o0", 0, 32'h0000_4581, 64'h8000_0200);
    flush    = 1'b1;
    flush_pc = 64'h9000_0000;
    tick(1);
    flush = 1'b0;
    tx_q.push_back('{32'h0000_4581, 64'h9000_0000});
    wait_log(3, 20, "t5b");
    chk_out("t5_o1", 1, 32'h0000_4581, 64'h9000_0000);
    chk_out("t5_o2", 2, 32'h0000_0000, 64'h9000_0002);

    // T6: asynchronous reset in the middle of the T2 stream
    tick(3);
    log_q.delete();
    push_t2();
    wait_log(1, 20, "t6");
    chk("t6_valid_before", 64'(instr_valid), 64'd1);
    #1;
    rst_n = 1'b0;
    tx_q.delete();
    fetch_valid = 1'b0;
    #1;
    chk("t6_valid_async", 64'(instr_valid), 64'd0);
    chk("t6_ready_async", 64'(fetch_ready), 64'd1);
    tick(2);
    rst_n = 1'b1;
    #1;
    chk("t6_valid_after", 64'(instr_valid), 64'd0);
    chk("t6_ready_after", 64'(fetch_ready), 64'd1);
    tick(3);
    chk("t6_count", 64'(log_q.size()), 64'd1);

    // Randomized traffic with redirects and backpressure
    next_addr = 64'h4000_0000;
    for (int it = 0; it < 6000; it++) begin
      if (it % 1000 == 0) begin
        vprob = int'($urandom_range(30, 100));
        rprob = int'($urandom_range(30, 100));
      end
      if ($urandom_range(0, 99) < 3) begin
        flush    = 1'b1;
        flush_pc = {$urandom(), $urandom()};
        tx_q.delete();
        fetch_valid = 1'b0;
        next_addr   = flush_pc & ~64'h3;
        tick(1);
        flush = 1'b0;
      end
      while (tx_q.size() < 3) begin
        tx_q.push_back('{{rand_half(), rand_half()}, next_addr});
        next_addr = next_addr + 64'd4;
      end
      tick(1);
    end
    vprob = 100;
    rprob = 100;
    tick(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
